// File: rtl/imm_extend_pipe.sv
// Immediate extender with a 2-entry result buffer and valid/ready handshakes on both sides.
// Define IMM_EXTEND_LUI_EN to give mode 11 upper-immediate placement; otherwise mode 11 is flagged via out_err.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [1:0]       occupancy
);

  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;

  logic [1:0]       occ_q, occ_d;
  logic [OUT_W-1:0] head_data_q, head_data_d;
  logic             head_err_q, head_err_d;
  logic [OUT_W-1:0] tail_data_q, tail_data_d;
  logic             tail_err_q, tail_err_d;

  logic push;
  logic pop;

  always_comb begin
    zext     = {{EXT_W{1'b0}}, in_imm};
    sext     = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    ext_data = zext;
    ext_err  = 1'b0;
    case (in_mode)
      2'b00: ext_data = zext;
      2'b01: ext_data = sext;
      2'b10: ext_data = {sext[OUT_W-3:0], 2'b00};
      default: begin
`ifdef IMM_EXTEND_LUI_EN
        ext_data = {in_imm, {EXT_W{1'b0}}};
        ext_err  = 1'b0;
`else
        ext_data = zext;
        ext_err  = 1'b1;
`endif
      end
    endcase
  end

  assign in_ready  = (occ_q != 2'd2) & ~reset;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_err   = head_err_q;
  assign occupancy = occ_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // The head register doubles as the output, so it keeps its last value once drained.
  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_err_d  = head_err_q;
    tail_data_d = tail_data_q;
    tail_err_d  = tail_err_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_data_d = ext_data;
          head_err_d  = ext_err;
          occ_d       = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = ext_data;
          head_err_d  = ext_err;
        end else if (push) begin
          tail_data_d = ext_data;
          tail_err_d  = ext_err;
          occ_d       = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_err_d  = tail_err_q;
          occ_d       = 2'd1;
        end
      end
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q       <= 2'd0;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      tail_data_q <= '0;
      tail_err_q  <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_err_q  <= head_err_d;
      tail_data_q <= tail_data_d;
      tail_err_q  <= tail_err_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and randomized checks of imm_extend_pipe at IN_W=16, OUT_W=32.
module tb_imm_extend_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [1:0]  occupancy;

  int tests = 0;
  int fails = 0;

  logic [32:0] q[$];
  logic [31:0] exp_lui_data;
  logic        exp_lui_err;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {err, data} for IN_W=16, OUT_W=32, written out per mode
  function automatic logic [32:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    case (mode)
      2'b00:   ref_ext = {1'b0, 16'h0000, imm};
      2'b01:   ref_ext = {1'b0, {16{imm[15]}}, imm};
      2'b10:   ref_ext = {1'b0, {14{imm[15]}}, imm, 2'b00};
`ifdef IMM_EXTEND_LUI_EN
      default: ref_ext = {1'b0, imm, 16'h0000};
`else
      default: ref_ext = {1'b1, 16'h0000, imm};
`endif
    endcase
  endfunction

  initial begin
`ifdef IMM_EXTEND_LUI_EN
    exp_lui_data = 32'h1234_0000;
    exp_lui_err  = 1'b0;
`else
    exp_lui_data = 32'h0000_1234;
    exp_lui_err  = 1'b1;
`endif
    reset = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // zero / sign / branch on 0x8005, back-to-back with out_ready high
    out_ready = 1'b1; in_valid = 1'b1; in_imm = 16'h8005; in_mode = 2'b00;
    tick();
    chk("m00_data", out_data, 32'h0000_8005);
    chk("m00_valid", 32'(out_valid), 32'd1);
    chk("m00_occ", 32'(occupancy), 32'd1);
    chk("m00_err", 32'(out_err), 32'd0);
    in_mode = 2'b01;
    tick();
    chk("m01_data", out_data, 32'hFFFF_8005);
    chk("m01_occ", 32'(occupancy), 32'd1);
    in_mode = 2'b10;
    tick();
    chk("m10_data", out_data, 32'hFFFE_0014);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_occ", 32'(occupancy), 32'd0);
    chk("drain_hold_data", out_data, 32'hFFFE_0014);
    tick();
    chk("empty_pop_occ", 32'(occupancy), 32'd0);
    chk("empty_pop_data", out_data, 32'hFFFE_0014);

    // mode 11, then a positive branch offset that must clear out_err
    in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'b11;
    tick();
    chk("m11_data", out_data, exp_lui_data);
    chk("m11_err", 32'(out_err), 32'(exp_lui_err));
    chk("m11_valid", 32'(out_valid), 32'd1);
    in_mode = 2'b10;
    tick();
    chk("m10_pos_data", out_data, 32'h0000_48D0);
    chk("m10_pos_err", 32'(out_err), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("m10_pos_drain", 32'(occupancy), 32'd0);

    // back-pressure: A,B accepted, C held until space frees
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b01; in_imm = 16'h0001;
    tick();
    chk("bp_a_occ", 32'(occupancy), 32'd1);
    in_imm = 16'h0002;
    tick();
    chk("bp_b_occ", 32'(occupancy), 32'd2);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    in_imm = 16'h0003;
    tick();
    chk("bp_c_held_occ", 32'(occupancy), 32'd2);
    chk("bp_stall_data", out_data, 32'h0000_0001);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", out_data, 32'h0000_0002);
    chk("bp_occ_after_pop", 32'(occupancy), 32'd1);
    tick();
    chk("bp_out_c", out_data, 32'h0000_0003);
    chk("bp_occ_c", 32'(occupancy), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(occupancy), 32'd0);

    // simultaneous push/pop at occupancy 1
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'h00AA;
    tick();
    chk("pp_x_data", out_data, 32'h0000_00AA);
    out_ready = 1'b1; in_mode = 2'b01; in_imm = 16'h7FFF;
    tick();
    chk("pp_occ", 32'(occupancy), 32'd1);
    chk("pp_head_new", out_data, 32'h0000_7FFF);
    in_valid = 1'b0;
    tick();
    chk("pp_drained", 32'(occupancy), 32'd0);

    // reset while full, with in_valid and out_ready asserted
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b01; in_imm = 16'hF00F;
    tick(); tick();
    chk("rf_full", 32'(occupancy), 32'd2);
    reset = 1'b1; out_ready = 1'b1;
    tick();
    chk("rf_occ", 32'(occupancy), 32'd0);
    chk("rf_valid", 32'(out_valid), 32'd0);
    chk("rf_data", out_data, 32'h0);
    chk("rf_err", 32'(out_err), 32'd0);
    chk("rf_in_ready_in_reset", 32'(in_ready), 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("rf_in_ready_after", 32'(in_ready), 32'd1);
    tick();
    chk("rf_still_empty", 32'(occupancy), 32'd0);

    // random stream against an in-order reference queue
    for (int cyc = 0; cyc < 1000; cyc++) begin
      int sz;
      sz = q.size();
      chk("rnd_occ", 32'(occupancy), 32'(sz));
      chk("rnd_valid", 32'(out_valid), 32'(sz != 0));
      chk("rnd_in_ready", 32'(in_ready), 32'(sz < 2));
      if (sz != 0) begin
        chk("rnd_data", out_data, q[0][31:0]);
        chk("rnd_err", 32'(out_err), 32'(q[0][32]));
      end
      in_valid  = 1'($urandom_range(0, 1));
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      if (sz != 0 && out_ready) void'(q.pop_front());
      if (in_valid && sz < 2) q.push_back(ref_ext(in_imm, in_mode));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("final_empty", 32'(occupancy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
